ram_popcount_sweeper: RTL and testbench

//  Controller that scans an address range of the 32x4 RAM (ram32x4) and runs a bit-serial popcount on each word.
//  It accumulates the total number of 1s and records the address of the word with the highest popcount.

---
 rtl/ram_popcount_sweeper.sv | 181 ++++++++++++++++++
 tb/tb_ram_popcount_sweeper.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_popcount_sweeper.sv
// Sweeps an inclusive address range of a small RAM, popcounts each word bit-serially,
// and reports the running total plus the address of the first word with the highest count.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; results from the previous sweep are held
// S_READ  | ram_addr stable, waiting RD_LAT clocks for read data
// S_LOAD  | capture ram_rdata into the shift register, clear bit counter
// S_SHIFT | shift one bit per clock until the shift register is empty
// S_ACC   | fold the word count into total/max, step or finish
// S_DONE  | results valid; leave when start is released
module ram_popcount_sweeper #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1,
    parameter int TOT_W  = $clog2((2**ADDR_W)*DATA_W+1),
    parameter int CNT_W  = $clog2(DATA_W+1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_first_addr,
    input  logic [ADDR_W-1:0] i_last_addr,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [TOT_W-1:0]  o_total,
    output logic [CNT_W-1:0]  o_max_cnt,
    output logic [ADDR_W-1:0] o_max_addr
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_SHIFT,
        S_ACC,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [ADDR_W-1:0]   r_last;
    logic [WAIT_W-1:0]   r_wait;
    logic [DATA_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_cnt;
    logic [TOT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_max_cnt;
    logic [ADDR_W-1:0]   r_max_addr;
    logic                r_err;
    logic                w_bad_range;
    logic                w_last_word;

    assign w_bad_range = (i_first_addr > i_last_addr);
    assign w_last_word = (r_ram_addr == r_last);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = w_bad_range ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (r_wait == '0) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_shreg == '0) begin
                    w_next = S_ACC;
                end
            end
            S_ACC: begin
                w_next = w_last_word ? S_DONE : S_READ;
            end
            S_DONE: begin
                if (!i_start) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: the wait timer is a down-counter reloaded on every entry to S_READ.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ram_addr <= '0;
            r_last     <= '0;
            r_wait     <= '0;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_total    <= '0;
            r_max_cnt  <= '0;
            r_max_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_last     <= i_last_addr;
                        r_total    <= '0;
                        r_max_cnt  <= '0;
                        r_max_addr <= '0;
                        if (w_bad_range) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ram_addr <= i_first_addr;
                            r_wait     <= WAIT_LOAD;
                        end
                    end
                end
                S_READ: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_LOAD: begin
                    r_shreg <= i_ram_rdata;
                    r_cnt   <= '0;
                end
                S_SHIFT: begin
                    if (r_shreg != '0) begin
                        r_cnt   <= r_cnt + CNT_W'(r_shreg[0]);
                        r_shreg <= r_shreg >> 1;
                    end
                end
                S_ACC: begin
                    r_total <= r_total + TOT_W'(r_cnt);
                    // Strictly greater keeps the lowest address on ties.
                    if (r_cnt > r_max_cnt) begin
                        r_max_cnt  <= r_cnt;
                        r_max_addr <= r_ram_addr;
                    end
                    if (!w_last_word) begin
                        r_ram_addr <= r_ram_addr + ADDR_W'(1);
                        r_wait     <= WAIT_LOAD;
                    end
                end
                S_DONE: begin
                    if (!i_start) begin
                        r_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ram_addr = r_ram_addr;
    assign o_busy     = (r_state == S_READ) || (r_state == S_LOAD) ||
                        (r_state == S_SHIFT) || (r_state == S_ACC);
    assign o_done     = (r_state == S_DONE);
    assign o_err      = r_err;
    assign o_total    = r_total;
    assign o_max_cnt  = r_max_cnt;
    assign o_max_addr = r_max_addr;

endmodule

// File: tb/tb_ram_popcount_sweeper.sv
// Self-checking bench: a range-level model predicts sweep length and results,
// checked every cycle; directed literal cases pin the model's arithmetic.
module tb_ram_popcount_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] first_addr;
    logic [4:0] last_addr;
    logic [4:0] ram_addr;
    logic [3:0] ram_rdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] total;
    logic [2:0] max_cnt;
    logic [4:0] max_addr;

    logic [3:0] mem [32];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_popcount_sweeper dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_first_addr (first_addr),
        .i_last_addr  (last_addr),
        .o_ram_addr   (ram_addr),
        .i_ram_rdata  (ram_rdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_total      (total),
        .o_max_cnt    (max_cnt),
        .o_max_addr   (max_addr)
    );

    // One-cycle read latency RAM
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popc(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int shift_cycles(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i + 2;
        return 1;
    endfunction

    // Model: phase 0 idle, 1 busy, 2 done
    bit m_valid = 0;
    int m_phase = 0;
    int m_left  = 0;
    int m_total = 0;
    int m_max   = 0;
    int m_maddr = 0;
    int m_addr  = 0;
    bit m_err   = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", int'(busy), int'(m_phase == 1));
            check("done", int'(done), int'(m_phase == 2));
            check("err", int'(err), int'(m_err));
            if (m_phase != 1) begin
                check("total", int'(total), m_total);
                check("max_cnt", int'(max_cnt), m_max);
                check("max_addr", int'(max_addr), m_maddr);
                check("ram_addr", int'(ram_addr), m_addr);
            end
        end
        if (reset) begin
            m_valid = 1;
            m_phase = 0;
            m_left  = 0;
            m_total = 0;
            m_max   = 0;
            m_maddr = 0;
            m_addr  = 0;
            m_err   = 0;
        end else if (m_valid) begin
            case (m_phase)
                0: if (start) begin
                    m_total = 0;
                    m_max   = 0;
                    m_maddr = 0;
                    if (first_addr > last_addr) begin
                        m_err   = 1;
                        m_phase = 2;
                    end else begin
                        m_left = 0;
                        for (int a = int'(first_addr); a <= int'(last_addr); a++) begin
                            m_total += popc(mem[a]);
                            if (popc(mem[a]) > m_max) begin
                                m_max   = popc(mem[a]);
                                m_maddr = a;
                            end
                            m_left += 1 + 1 + shift_cycles(mem[a]) + 1;
                        end
                        m_addr  = int'(last_addr);
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (!start) begin
                    m_phase = 0;
                    m_err   = 0;
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input int f, input int l);
        first_addr = 5'(f);
        last_addr  = 5'(l);
        start      = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick(1);
            cycles++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic release_start();
        start = 1'b0;
        tick(1);
    endtask

    task automatic check_results(input string name, input int t, input int mc, input int ma);
        check({name, "_total"}, int'(total), t);
        check({name, "_max_cnt"}, int'(max_cnt), mc);
        check({name, "_max_addr"}, int'(max_addr), ma);
    endtask

    initial begin
        int c;
        int f;
        int l;
        reset      = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        for (int i = 0; i < 32; i++) mem[i] = 4'(i);
        tick(3);
        reset = 1'b0;
        tick(1);

        // T3 bad range straight out of reset
        launch(9, 3);
        tick(1);
        check("T3_done", int'(done), 1);
        check("T3_err", int'(err), 1);
        check("T3_total", int'(total), 0);
        check("T3_ram_addr", int'(ram_addr), 0);
        release_start();
        check("T3_err_clear", int'(err), 0);

        // T1 full sweep
        launch(0, 31);
        wait_done("T1", 400, c);
        check_results("T1", 64, 4, 15);
        check("T1_err", int'(err), 0);
        release_start();

        // T2 single words and minimum latency
        mem[5] = 4'h5;
        launch(5, 5);
        wait_done("T2a", 50, c);
        check_results("T2a", 2, 2, 5);
        release_start();
        mem[0] = 4'h0;
        launch(0, 0);
        wait_done("T2b", 50, c);
        check("T2b_latency", c, 5);
        check("T2b_total", int'(total), 0);
        release_start();

        // T4 start dropped and re-pulsed mid-sweep, then held through done
        launch(0, 31);
        tick(10);
        start = 1'b0;
        tick(7);
        start = 1'b1;
        wait_done("T4", 400, c);
        check_results("T4", 64, 4, 15);
        tick(3);
        check("T4_hold_done", int'(done), 1);
        release_start();
        check("T4_idle_done", int'(done), 0);
        check("T4_idle_err", int'(err), 0);
        check("T4_idle_busy", int'(busy), 0);

        // T5 reset mid-SHIFT, then rerun
        launch(0, 31);
        tick(7);
        check("T5_pre_busy", int'(busy), 1);
        start = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("T5_busy", int'(busy), 0);
        check("T5_done", int'(done), 0);
        check("T5_total", int'(total), 0);
        check("T5_ram_addr", int'(ram_addr), 0);
        tick(1);
        launch(0, 31);
        wait_done("T5_rerun", 400, c);
        check_results("T5_rerun", 64, 4, 15);
        release_start();

        // T6 tie handling
        mem[2] = 4'h3;
        mem[3] = 4'hC;
        mem[4] = 4'h7;
        launch(2, 4);
        wait_done("T6a", 100, c);
        check_results("T6a", 7, 3, 4);
        release_start();
        launch(2, 3);
        wait_done("T6b", 100, c);
        check_results("T6b", 4, 2, 2);
        release_start();

        // Randomized sweeps against the model
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 32; i++) mem[i] = 4'($urandom);
            f = int'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) l = int'($urandom_range(0, 31));
            else l = int'($urandom_range(f, 31));
            launch(f, l);
            if (f <= l && $urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(1, 3)));
                start = 1'b0;
            end
            wait_done("rand", 400, c);
            release_start();
            tick(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
